// File: rtl/gzip_pkg.sv
// Shared types and sizes for the gzip trailer controller and its CRC engine.
// The optional ISIZE trailer words are enabled by GZIP_TRAILER_ISIZE_EN.
package gzip_pkg;

  localparam int CRC32_W          = 32;
  localparam int ISIZE_W          = 32;
  localparam int TRAILER_LEN_FULL = 8;
  localparam int TRAILER_LEN_CRC  = 4;

  typedef enum logic [1:0] {
    ST_CLR,
    ST_PASS,
    ST_WAIT,
    ST_TRAIL
  } state_t;

endpackage

// File: rtl/crc32.sv
// Byte-serial reflected CRC-32 (poly 0xEDB88320), synchronous active-low reset.
// Output is the finalised (inverted) CRC; valid once at least one byte was folded in.
module crc32
  import gzip_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         crc32_in,
  input  logic               crc32_valid_in,
  output logic [CRC32_W-1:0] crc32_out,
  output logic               crc32_valid_out
);

  logic [CRC32_W-1:0] crc_q;
  logic               seen_q;

  function automatic logic [CRC32_W-1:0] crc_step(input logic [CRC32_W-1:0] c,
                                                  input logic [7:0]         d);
    logic [CRC32_W-1:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q  <= '1;
      seen_q <= 1'b0;
    end else if (crc32_valid_in) begin
      crc_q  <= crc_step(crc_q, crc32_in);
      seen_q <= 1'b1;
    end
  end

  assign crc32_out       = ~crc_q;
  assign crc32_valid_out = seen_q;

endmodule

// File: rtl/gzip_trailer_ctrl.sv
// Passes payload through and appends the gzip trailer (CRC32, plus ISIZE when
// GZIP_TRAILER_ISIZE_EN is defined), little-endian.
//
// state    | meaning
// ST_CLR   | CRC engine held in reset for CLR_CYCLES cycles between frames
// ST_PASS  | payload passthrough, zero latency
// ST_WAIT  | one cycle to capture the finished CRC
// ST_TRAIL | emitting trailer bytes
module gzip_trailer_ctrl
  import gzip_pkg::*;
#(
  parameter int CLR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic [ISIZE_W-1:0] isize
);

`ifdef GZIP_TRAILER_ISIZE_EN
  localparam int TRAILER_LEN = TRAILER_LEN_FULL;
`else
  localparam int TRAILER_LEN = TRAILER_LEN_CRC;
`endif

  state_t             state;
  logic [3:0]         clr_cnt;
  logic [2:0]         tidx;
  logic [CRC32_W-1:0] crc_q;
  logic               busy_q;

  logic               in_xfer;
  logic               last_trail;
  logic               trail_done;
  logic               eng_rst_n;
  logic [CRC32_W-1:0] eng_crc;
  logic               eng_crc_valid;
  logic [63:0]        trail_word;

  assign in_ready   = (state == ST_PASS) & out_ready;
  assign in_xfer    = in_valid & in_ready;
  assign last_trail = (tidx == 3'(TRAILER_LEN - 1));
  assign trail_done = (state == ST_TRAIL) & out_ready & last_trail;

  assign out_valid  = (state == ST_PASS) ? in_valid : (state == ST_TRAIL);
  assign out_last   = (state == ST_TRAIL) & last_trail;
  assign trail_word = {isize, crc_q};
  assign out_data   = (state == ST_PASS)  ? in_data :
                      (state == ST_TRAIL) ? trail_word[{tidx, 3'b000} +: 8] : 8'h00;
  assign busy       = busy_q;

  assign eng_rst_n  = ~(rst | (state == ST_CLR));

  crc32 u_crc32 (
    .clk             (clk),
    .rst_n           (eng_rst_n),
    .crc32_in        (in_data),
    .crc32_valid_in  (in_xfer),
    .crc32_out       (eng_crc),
    .crc32_valid_out (eng_crc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLR;
      clr_cnt <= '0;
      tidx    <= '0;
      crc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
            state   <= ST_PASS;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 4'd1;
          end
        end
        ST_PASS: begin
          if (in_xfer) begin
            busy_q <= 1'b1;
            if (in_last) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // an engine that saw no bytes is a fault; emit a zero CRC rather than stall
          crc_q <= eng_crc_valid ? eng_crc : '0;
          tidx  <= '0;
          state <= ST_TRAIL;
        end
        ST_TRAIL: begin
          if (out_ready) begin
            if (last_trail) begin
              state  <= ST_CLR;
              tidx   <= '0;
              busy_q <= 1'b0;
            end else begin
              tidx <= tidx + 3'd1;
            end
          end
        end
        default: state <= ST_CLR;
      endcase
    end
  end

`ifdef GZIP_TRAILER_ISIZE_EN
  logic [ISIZE_W-1:0] isize_q;

  always_ff @(posedge clk) begin
    if (rst || trail_done) begin
      isize_q <= '0;
    end else if (in_xfer) begin
      isize_q <= isize_q + 32'd1;
    end
  end

  assign isize = isize_q;
`else
  assign isize = '0;
`endif

endmodule

// File: tb/tb_gzip_trailer_ctrl.sv
// Directed bench for gzip_trailer_ctrl; expectations follow GZIP_TRAILER_ISIZE_EN.
module tb_gzip_trailer_ctrl;
  import gzip_pkg::*;

  localparam int CLR_CYCLES = 2;
`ifdef GZIP_TRAILER_ISIZE_EN
  localparam bit ISZ_EN = 1'b1;
`else
  localparam bit ISZ_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic [31:0] isize;

  gzip_trailer_ctrl #(.CLR_CYCLES(CLR_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .isize     (isize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pay[$];
  logic [7:0] expq[$];

  typedef struct {
    int          kind;
    string       txt;
    logic [31:0] crc;
    bit          stall;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void fill(input int kind, input string txt);
    pay.delete();
    case (kind)
      0: for (int i = 0; i < txt.len(); i++) pay.push_back(txt[i]);
      1: for (int i = 0; i < 32; i++) pay.push_back(8'h00);
      2: for (int i = 0; i < 32; i++) pay.push_back(8'hFF);
      default: for (int i = 0; i < 32; i++) pay.push_back(8'(i));
    endcase
  endfunction

  // Drives one frame and checks every output transfer against the expected stream.
  task automatic run_frame(input logic [31:0] crc, input bit stall, input int abort_at,
                           output int pre_wait, output int lat);
    int n, len, idx, oidx, last_acc, first_tr;
    bit held, seen_acc;
    logic [7:0] held_d;
    logic [31:0] nsz;
    n = pay.size();
    nsz = 32'(n);
    expq.delete();
    foreach (pay[i]) expq.push_back(pay[i]);
    for (int i = 0; i < 4; i++) expq.push_back(crc[8*i +: 8]);
    if (ISZ_EN) for (int i = 0; i < 4; i++) expq.push_back(nsz[8*i +: 8]);
    len = expq.size();
    idx = 0; oidx = 0; pre_wait = 0; last_acc = -1; first_tr = -1;
    held = 1'b0; seen_acc = 1'b0; held_d = 8'h00; lat = -1;
    for (int cyc = 0; cyc < 3000 && oidx < len; cyc++) begin
      in_valid  = (idx < n);
      in_data   = (idx < n) ? pay[idx] : 8'h00;
      in_last   = (idx == n - 1);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held) check("stall_hold", {55'd0, out_valid, out_data}, {55'd0, 1'b1, held_d});
      held   = out_valid && !out_ready;
      held_d = out_data;
      if (!seen_acc && !in_ready) pre_wait++;
      if (in_valid && in_ready) begin
        seen_acc = 1'b1;
        idx++;
        if (idx == n) last_acc = cyc;
      end
      if (out_valid && oidx >= n && first_tr < 0) first_tr = cyc;
      if (abort_at >= 0 && oidx == abort_at && out_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      if (out_valid && out_ready) begin
        check("out_data", out_data, expq[oidx]);
        check("out_last", out_last, oidx == len - 1);
        if (oidx >= n) check("busy_trail", busy, 1);
        if (oidx == len - 1) check("isize", isize, ISZ_EN ? 64'(n) : 64'd0);
        oidx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("frame_done", oidx, len);
    lat = (first_tr >= 0 && last_acc >= 0) ? first_tr - last_acc : -1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_isize"},     isize,     0);
  endtask

  initial begin
    int pw, lat;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    vecs[0] = '{0, "0123456789", 32'hA684C7C6, 1'b0};
    vecs[1] = '{0, "a",          32'hE8B7BE43, 1'b0};
    vecs[2] = '{1, "",           32'h190A55AD, 1'b0};
    vecs[3] = '{2, "",           32'hFF6CAB0B, 1'b0};
    vecs[4] = '{3, "",           32'h91267E8A, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].kind, vecs[v].txt);
      run_frame(vecs[v].crc, vecs[v].stall, -1, pw, lat);
      if (!vecs[v].stall) check("clr_gap", pw, CLR_CYCLES);
      check("trail_latency", lat, 2);
      check("busy_after", busy, 0);
      check("isize_after", isize, 0);
    end

    // reset during trailer byte 3 abandons the frame; next frame starts clean
    fill(0, "0123456789");
    run_frame(32'hA684C7C6, 1'b0, 10 + 3, pw, lat);
    check_idle("midrst");
    fill(0, "The quick brown fox jumps over the lazy dog");
    run_frame(32'h414FA339, 1'b0, -1, pw, lat);
    check("clr_gap_rst", pw, CLR_CYCLES);
    check("trail_latency_rst", lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
